tge_pkt_sim_sched: RTL

- Packet-generation scheduler for the 10GbE test path.
- Consumes software-register values (payload_len, period, enable) already synchronised to user_clk, and drives the ten_gbe TX streaming interface.
- Emits a fixed-format test frame every `period` cycles: one header beat followed by payload_len counter beats.
- Honours TX almost-full back-pressure and counts overflow events for readback.

---
 rtl/tge_pkt_sim_sched.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/tge_pkt_sim_sched.sv
// tge_pkt_sim_sched: test-frame scheduler for the 10GbE TX streaming path.
// Emits one header beat plus payload_len counter beats every `period` cycles,
// stalls beat issue while tx_afull is high, and keeps a saturating count of
// tx_overflow cycles. All outputs are registered.
// A beat appearing in cycle t is decided from inputs sampled in cycle t-1.
// Optional build macro PKT_SIM_TIMESTAMP_EN replaces the header length field
// with a free-running 32-bit cycle timestamp.
module tge_pkt_sim_sched #(
  parameter int DATA_W   = 64,
  parameter int LEN_W    = 16,
  parameter int PERIOD_W = 32,
  parameter int OVF_W    = 16
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                enable,
  input  logic [LEN_W-1:0]    payload_len,
  input  logic [PERIOD_W-1:0] period,
  input  logic                tx_afull,
  input  logic                tx_overflow,
  output logic                tx_valid,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_end_of_frame,
  output logic [31:0]         pkt_count,
  output logic [OVF_W-1:0]    overflow_count,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  state_t              state_r, state_n_s;
  logic [LEN_W-1:0]    len_r;      // payload length latched with the header
  logic [PERIOD_W-1:0] pm1_r;      // max(period,1)-1 latched with the header
  logic [PERIOD_W-1:0] cnt_r;      // cycles since last header, saturating
  logic [LEN_W-1:0]    idx_r;      // index of the last issued payload beat
  logic [31:0]         seq_r;
  logic [OVF_W-1:0]    ovf_r;
  logic                tx_valid_r, tx_eof_r, busy_r;
  logic [DATA_W-1:0]   tx_data_r;

  logic                eof_now_s, start_ok_s, issue_hdr_s, issue_pay_s;
  logic [31:0]         seq_next_s;
  logic [LEN_W-1:0]    idx_inc_s;
  logic [DATA_W-1:0]   hdr_data_s, pay_data_s;

`ifdef PKT_SIM_TIMESTAMP_EN
  logic [31:0]         ts_r;

  // Free-running cycle timestamp, wraps naturally.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ts_r <= 32'd0;
    end else begin
      ts_r <= ts_r + 32'd1;
    end
  end

  // The header carries the timestamp of the cycle in which it appears.
  assign hdr_data_s = {seq_next_s, ts_r + 32'd1};
`else
  assign hdr_data_s = {seq_next_s, 16'h0000, 16'(payload_len)};
`endif

  // The beat on the output right now is the last one of its frame.
  assign eof_now_s  = tx_valid_r & tx_eof_r;
  // Next header may appear next cycle: period elapsed, enabled, room in FIFO.
  assign start_ok_s = enable & ~tx_afull & (cnt_r >= pm1_r);
  // A frame ending now bumps the sequence number for the following header.
  assign seq_next_s = eof_now_s ? (seq_r + 32'd1) : seq_r;
  assign idx_inc_s  = idx_r + LEN_W'(1);
  assign pay_data_s = {seq_r, 32'(idx_inc_s)};

  // Next-state and beat-issue decision for the cycle ahead.
  always_comb begin
    state_n_s   = state_r;
    issue_hdr_s = 1'b0;
    issue_pay_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && !tx_afull) begin
          state_n_s   = ST_HDR;
          issue_hdr_s = 1'b1;
        end else begin
          state_n_s   = ST_IDLE;
        end
      end
      ST_HDR, ST_PAY: begin
        if (eof_now_s) begin
          if (start_ok_s) begin
            state_n_s   = ST_HDR;
            issue_hdr_s = 1'b1;
          end else if (!enable) begin
            state_n_s   = ST_IDLE;
          end else begin
            state_n_s   = ST_WAIT;
          end
        end else begin
          // Frame still has payload; it always completes, enable or not.
          state_n_s   = ST_PAY;
          issue_pay_s = ~tx_afull;
        end
      end
      ST_WAIT: begin
        if (start_ok_s) begin
          state_n_s   = ST_HDR;
          issue_hdr_s = 1'b1;
        end else if (!enable) begin
          state_n_s   = ST_IDLE;
        end else begin
          state_n_s   = ST_WAIT;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, busy flag and sequence number.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      seq_r   <= 32'd0;
    end else begin
      state_r <= state_n_s;
      busy_r  <= (state_n_s != ST_IDLE);
      seq_r   <= seq_next_s;
    end
  end

  // Saturating overflow counter, independent of the FSM.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      ovf_r <= {OVF_W{1'b0}};
    end else if (tx_overflow && (ovf_r != {OVF_W{1'b1}})) begin
      ovf_r <= ovf_r + OVF_W'(1);
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Header-to-header spacing counter; restarts at each header, never wraps.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      cnt_r <= {PERIOD_W{1'b0}};
    end else if (issue_hdr_s) begin
      cnt_r <= {PERIOD_W{1'b0}};
    end else if (cnt_r != {PERIOD_W{1'b1}}) begin
      cnt_r <= cnt_r + PERIOD_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Beat generation; a stalled cycle drops valid but holds data and index.
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      len_r      <= {LEN_W{1'b0}};
      pm1_r      <= {PERIOD_W{1'b0}};
      idx_r      <= {LEN_W{1'b0}};
      tx_valid_r <= 1'b0;
      tx_data_r  <= {DATA_W{1'b0}};
      tx_eof_r   <= 1'b0;
    end else if (issue_hdr_s) begin
      len_r      <= payload_len;
      pm1_r      <= (period == {PERIOD_W{1'b0}}) ? {PERIOD_W{1'b0}} : (period - PERIOD_W'(1));
      idx_r      <= {LEN_W{1'b0}};
      tx_valid_r <= 1'b1;
      tx_data_r  <= hdr_data_s;
      tx_eof_r   <= (payload_len == {LEN_W{1'b0}});
    end else if (issue_pay_s) begin
      idx_r      <= idx_inc_s;
      tx_valid_r <= 1'b1;
      tx_data_r  <= pay_data_s;
      tx_eof_r   <= (idx_inc_s == len_r);
    end else begin
      tx_valid_r <= 1'b0;
    end
  end

  assign tx_valid        = tx_valid_r;
  assign tx_data         = tx_data_r;
  assign tx_end_of_frame = tx_eof_r;
  assign pkt_count       = seq_r;
  assign overflow_count  = ovf_r;
  assign busy            = busy_r;

endmodule
